// File: rtl/bus_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_transfer_ctrl
//
// Sequences a single register-to-register move over a shared bus. A request
// names a source register (driven onto the bus) and a destination register
// (loaded from the bus), with an optional post-increment of the source. The
// controller produces one-hot output-enable, load and increment strobes for the
// attached register bank.
//
// Ports
//   clock       : single clock, all state changes on the rising edge
//   reset       : asynchronous, active-low reset
//   req_valid   : transfer request present
//   req_ready   : request accepted this cycle (combinational, high in IDLE)
//   req_src     : index of register driving the bus
//   req_dst     : index of register loading from the bus
//   req_inc     : increment the source register after the transfer
//   enable_out  : one-hot per-register bus output enable   (registered)
//   load_out    : one-hot per-register load strobe          (registered)
//   count_out   : one-hot per-register increment strobe     (registered)
//   busy        : transfer in progress                      (registered)
//   done        : one-cycle pulse on transfer completion    (registered)
//   error       : one-cycle pulse on request rejection      (registered)
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; first IDLE cycle after LATCH shows done
// DRIVE   | source register drives the bus, destination not yet loading
// LATCH   | source still driving, destination loads, optional src increment
// -----------------------------------------------------------------------------
module bus_transfer_ctrl #(
   parameter int NUM_REGS  = 8,
   parameter int SEL_WIDTH = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [SEL_WIDTH-1:0] req_src,
   input  logic [SEL_WIDTH-1:0] req_dst,
   input  logic                 req_inc,
   output logic [NUM_REGS-1:0]  enable_out,
   output logic [NUM_REGS-1:0]  load_out,
   output logic [NUM_REGS-1:0]  count_out,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam logic [NUM_REGS-1:0] ONE_BIT = NUM_REGS'(1);

   state_t               state;
   state_t               state_nxt;

   logic [SEL_WIDTH-1:0] src_q;
   logic [SEL_WIDTH-1:0] dst_q;
   logic                 inc_q;
   logic [SEL_WIDTH-1:0] src_nxt;
   logic [SEL_WIDTH-1:0] dst_nxt;
   logic                 inc_nxt;

   logic [NUM_REGS-1:0]  enable_nxt;
   logic [NUM_REGS-1:0]  load_nxt;
   logic [NUM_REGS-1:0]  count_nxt;
   logic                 busy_nxt;
   logic                 done_nxt;
   logic                 error_nxt;

   logic                 accept;
   logic                 req_bad;

   // Index values outside the bank shift the single set bit off the top,
   // so an out-of-range index can never light a strobe.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
      return ONE_BIT << idx;
   endfunction

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;

   // Widened compare so the range test also works when SEL_WIDTH can encode
   // indices beyond the last register.
   assign req_bad = (req_src == req_dst)
                 || (int'(req_src) >= NUM_REGS)
                 || (int'(req_dst) >= NUM_REGS);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         src_q <= '0;
         dst_q <= '0;
         inc_q <= 1'b0;
      end else begin
         state <= state_nxt;
         src_q <= src_nxt;
         dst_q <= dst_nxt;
         inc_q <= inc_nxt;
      end
   end

   // Next-state and next-output decode. Outputs are computed one state ahead
   // so that the registered strobes line up with the state they belong to.
   always_comb begin
      state_nxt  = state;
      src_nxt    = src_q;
      dst_nxt    = dst_q;
      inc_nxt    = inc_q;
      enable_nxt = '0;
      load_nxt   = '0;
      count_nxt  = '0;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      error_nxt  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (req_bad) begin
                  error_nxt = 1'b1;
               end else begin
                  state_nxt  = ST_DRIVE;
                  src_nxt    = req_src;
                  dst_nxt    = req_dst;
                  inc_nxt    = req_inc;
                  enable_nxt = onehot(req_src);
                  busy_nxt   = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            // Source keeps driving through LATCH so the destination samples a
            // bus value that has been stable for a full cycle.
            state_nxt  = ST_LATCH;
            enable_nxt = onehot(src_q);
            load_nxt   = onehot(dst_q);
            count_nxt  = inc_q ? onehot(src_q) : '0;
            busy_nxt   = 1'b1;
         end
         ST_LATCH: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         enable_out <= '0;
         load_out   <= '0;
         count_out  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         enable_out <= enable_nxt;
         load_out   <= load_nxt;
         count_out  <= count_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         error      <= error_nxt;
      end
   end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_transfer_ctrl
//
// Drives bus_transfer_ctrl with a table of single requests, a few directed
// multi-cycle sequences and a randomized run. A small register bank is attached
// to the strobes so data movement can be observed. Every cycle the outputs are
// compared with a schedule-based reference: an accepted request at cycle c
// books the enables at c+1/c+2, the load and increment at c+2 and done at c+3.
// -----------------------------------------------------------------------------
module tb_bus_transfer_ctrl;

   localparam int NR   = 8;
   localparam int SW   = 4;
   localparam int MAXC = 4096;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [SW-1:0] req_src = '0;
   logic [SW-1:0] req_dst = '0;
   logic          req_inc = 1'b0;
   logic [NR-1:0] enable_out;
   logic [NR-1:0] load_out;
   logic [NR-1:0] count_out;
   logic          busy;
   logic          done;
   logic          error;

   bus_transfer_ctrl #(.NUM_REGS(NR), .SEL_WIDTH(SW)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_src    (req_src),
      .req_dst    (req_dst),
      .req_inc    (req_inc),
      .enable_out (enable_out),
      .load_out   (load_out),
      .count_out  (count_out),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Attached register bank, driven only by the controller strobes.
   logic [15:0] hw_regs [NR] = '{16'h0010, 16'h0111, 16'h0212, 16'h0313,
                                 16'h0414, 16'h0515, 16'h0616, 16'h0717};
   logic [15:0] bus_val;

   always_comb begin
      bus_val = '0;
      for (int i = 0; i < NR; i++)
         if (enable_out[i]) bus_val = bus_val | hw_regs[i];
   end

   always @(posedge clock) begin
      for (int i = 0; i < NR; i++) begin
         if (load_out[i])       hw_regs[i] <= bus_val;
         else if (count_out[i]) hw_regs[i] <= hw_regs[i] + 16'd1;
      end
   end

   // ---------------- reference model ----------------
   int          cyc       = 0;
   int          free_from = 0;
   logic [NR-1:0] exp_en  [MAXC];
   logic [NR-1:0] exp_ld  [MAXC];
   logic [NR-1:0] exp_cn  [MAXC];
   logic          exp_bsy [MAXC];
   logic          exp_dn  [MAXC];
   logic          exp_er  [MAXC];
   logic [15:0] ref_regs [NR] = '{16'h0010, 16'h0111, 16'h0212, 16'h0313,
                                  16'h0414, 16'h0515, 16'h0616, 16'h0717};
   bit          pend_valid = 0;
   int          pend_at    = 0;
   int          pend_src   = 0;
   int          pend_dst   = 0;
   bit          pend_inc   = 0;

   initial begin
      for (int i = 0; i < MAXC; i++) begin
         exp_en[i] = '0; exp_ld[i] = '0; exp_cn[i] = '0;
         exp_bsy[i] = 0; exp_dn[i] = 0; exp_er[i] = 0;
      end
   end

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = cyc; k < cyc + 4; k++) begin
            exp_en[k] = '0; exp_ld[k] = '0; exp_cn[k] = '0;
            exp_bsy[k] = 0; exp_dn[k] = 0; exp_er[k] = 0;
         end
         free_from  = cyc;
         pend_valid = 0;
      end else begin
         if (pend_valid && cyc == pend_at) begin
            ref_regs[pend_dst] = ref_regs[pend_src];
            if (pend_inc) ref_regs[pend_src] = ref_regs[pend_src] + 16'd1;
            pend_valid = 0;
         end
         if (req_valid && cyc >= free_from) begin
            int s, d;
            s = int'(req_src);
            d = int'(req_dst);
            if (s == d || s >= NR || d >= NR) begin
               exp_er[cyc+1] = 1;
            end else begin
               exp_en[cyc+1]  = NR'(1) << s;
               exp_en[cyc+2]  = NR'(1) << s;
               exp_ld[cyc+2]  = NR'(1) << d;
               exp_cn[cyc+2]  = req_inc ? (NR'(1) << s) : '0;
               exp_bsy[cyc+1] = 1;
               exp_bsy[cyc+2] = 1;
               exp_dn[cyc+3]  = 1;
               free_from      = cyc + 3;
               pend_valid     = 1;
               pend_at        = cyc + 2;
               pend_src       = s;
               pend_dst       = d;
               pend_inc       = req_inc;
            end
         end
         cyc = cyc + 1;
      end
   end

   always @(negedge clock) begin
      check("ready",    32'(req_ready),  32'(cyc >= free_from));
      check("enable",   32'(enable_out), 32'(exp_en[cyc]));
      check("load",     32'(load_out),   32'(exp_ld[cyc]));
      check("count",    32'(count_out),  32'(exp_cn[cyc]));
      check("busy",     32'(busy),       32'(exp_bsy[cyc]));
      check("done",     32'(done),       32'(exp_dn[cyc]));
      check("error",    32'(error),      32'(exp_er[cyc]));
      check("onehot",   32'(($countones(enable_out) <= 1) && ($countones(load_out) <= 1)
                            && ($countones(count_out) <= 1)), 32'(1));
      check("done_err", 32'(done && error), 32'(0));
      for (int i = 0; i < NR; i++)
         check("regfile", 32'(hw_regs[i]), 32'(ref_regs[i]));
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [SW-1:0] src;
      logic [SW-1:0] dst;
      logic          inc;
      logic          err;
      logic [NR-1:0] en;
      logic [NR-1:0] ld;
      logic [NR-1:0] cn;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [10:0] done_mask;

      vecs[0] = '{src: 4'd2,  dst: 4'd5, inc: 1'b0, err: 1'b0, en: 8'h04, ld: 8'h20, cn: 8'h00};
      vecs[1] = '{src: 4'd0,  dst: 4'd1, inc: 1'b1, err: 1'b0, en: 8'h01, ld: 8'h02, cn: 8'h01};
      vecs[2] = '{src: 4'd3,  dst: 4'd3, inc: 1'b0, err: 1'b1, en: 8'h00, ld: 8'h00, cn: 8'h00};
      vecs[3] = '{src: 4'd8,  dst: 4'd1, inc: 1'b0, err: 1'b1, en: 8'h00, ld: 8'h00, cn: 8'h00};
      vecs[4] = '{src: 4'd1,  dst: 4'd8, inc: 1'b1, err: 1'b1, en: 8'h00, ld: 8'h00, cn: 8'h00};
      vecs[5] = '{src: 4'd7,  dst: 4'd0, inc: 1'b1, err: 1'b0, en: 8'h80, ld: 8'h01, cn: 8'h80};
      vecs[6] = '{src: 4'd15, dst: 4'd2, inc: 1'b0, err: 1'b1, en: 8'h00, ld: 8'h00, cn: 8'h00};

      #1;
      check("reset_ready", 32'(req_ready), 32'(1));
      check("reset_strb",  32'({enable_out, load_out, count_out, busy, done, error}), 32'(0));
      repeat (3) @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 7; i++) begin
         @(posedge clock); #1;
         req_valid = 1'b1;
         req_src   = vecs[i].src;
         req_dst   = vecs[i].dst;
         req_inc   = vecs[i].inc;
         @(posedge clock); #1;
         req_valid = 1'b0;
         @(negedge clock);
         check("v_err1", 32'(error), 32'(vecs[i].err));
         check("v_en1",  32'(enable_out), 32'(vecs[i].en));
         check("v_ld1",  32'(load_out), 32'(0));
         check("v_rdy1", 32'(req_ready), 32'(vecs[i].err));
         @(negedge clock);
         check("v_err2", 32'(error), 32'(0));
         check("v_en2",  32'(enable_out), 32'(vecs[i].en));
         check("v_ld2",  32'(load_out), 32'(vecs[i].ld));
         check("v_cn2",  32'(count_out), 32'(vecs[i].cn));
         @(negedge clock);
         check("v_done3", 32'(done), 32'(!vecs[i].err));
         check("v_en3",   32'(enable_out), 32'(0));
         if (i == 0) check("reg5_eq_reg2", 32'(hw_regs[5]), 32'(hw_regs[2]));
         if (i == 1) begin
            check("reg1_val", 32'(hw_regs[1]), 32'(16'h0010));
            check("reg0_inc", 32'(hw_regs[0]), 32'(16'h0011));
         end
      end

      // Three queued requests with valid held high; fields changed while busy.
      @(posedge clock); #1;
      req_valid = 1'b1;
      req_src = 4'd1; req_dst = 4'd2; req_inc = 1'b0;
      @(posedge clock); #1;
      done_mask = '0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         done_mask[k] = done;
         if (k == 1) begin req_src = 4'd4; req_dst = 4'd6; req_inc = 1'b1; end
         if (k == 4) begin req_src = 4'd6; req_dst = 4'd3; req_inc = 1'b0; end
         if (k == 7) req_valid = 1'b0;
      end
      check("b2b_done_mask", 32'(done_mask), 32'(11'b010_0100_1000));

      // Source/destination toggled during DRIVE must not disturb the transfer.
      @(posedge clock); #1;
      req_valid = 1'b1; req_src = 4'd4; req_dst = 4'd6; req_inc = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(negedge clock);
      req_src = 4'd1; req_dst = 4'd2;
      @(negedge clock);
      check("toggle_en", 32'(enable_out), 32'(8'h10));
      check("toggle_ld", 32'(load_out),   32'(8'h40));
      @(negedge clock);

      // Reset asserted mid-LATCH.
      @(posedge clock); #1;
      req_valid = 1'b1; req_src = 4'd1; req_dst = 4'd3; req_inc = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rst_pre_ld", 32'(load_out), 32'(8'h08));
      #2 reset = 1'b0;
      #1;
      check("rst_async_strb", 32'({enable_out, load_out, count_out}), 32'(0));
      check("rst_async_busy", 32'(busy), 32'(0));
      @(negedge clock);
      check("rst_no_done", 32'(done), 32'(0));
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check("rst_ready", 32'(req_ready), 32'(1));
      check("rst_done",  32'(done), 32'(0));
      @(negedge clock);

      // Randomized traffic, checked every cycle against the reference.
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         req_valid = 1'($urandom_range(0, 1));
         req_src   = SW'($urandom_range(0, 9));
         req_dst   = SW'($urandom_range(0, 9));
         req_inc   = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      req_valid = 1'b0;
      repeat (5) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
